// File: rtl/eth_pkg.sv
// Shared Ethernet/IPv4/UDP constants and receive-parser state encoding.
// Header byte indices are positions within their own header, counted from 0.
package eth_pkg;

  localparam logic [7:0]  ETH_PREAMBLE   = 8'h55;
  localparam logic [7:0]  ETH_SFD        = 8'hD5;
  localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
  localparam logic [7:0]  IP_VER_IHL     = 8'h45;
  localparam logic [7:0]  IP_PROTO_UDP   = 8'd17;

  localparam logic [31:0] CRC32_POLY     = 32'h04C11DB7;
  localparam logic [31:0] CRC32_INIT     = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_RESIDUE  = 32'hC704DD7B;

  localparam int ETH_HDR_LEN  = 14;
  localparam int IP_HDR_LEN   = 20;
  localparam int UDP_HDR_LEN  = 8;
  localparam int PREAMBLE_MAX = 7;

  localparam logic [5:0] ETH_MAC_END   = 6'd5;
  localparam logic [5:0] ETH_TYPE_END  = 6'(ETH_HDR_LEN - 1);
  localparam logic [5:0] IP_VER_IDX    = 6'd0;
  localparam logic [5:0] IP_PROTO_IDX  = 6'd9;
  localparam logic [5:0] IP_SRC_END    = 6'd15;
  localparam logic [5:0] IP_DST_END    = 6'(IP_HDR_LEN - 1);
  localparam logic [5:0] UDP_SPORT_END = 6'd1;
  localparam logic [5:0] UDP_DPORT_END = 6'd3;
  localparam logic [5:0] UDP_LEN_END   = 6'd5;
  localparam logic [5:0] UDP_HDR_END   = 6'(UDP_HDR_LEN - 1);

  typedef enum logic [3:0] {
    WAIT_IDLE,
    IDLE,
    PREAMBLE,
    ETH_HDR,
    IP_HDR,
    UDP_HDR,
    PAYLOAD,
    TAIL,
    DROP
  } rx_state_e;

endpackage

// File: rtl/crc32_d8.sv
// Combinational Ethernet CRC32 step for one byte, bits consumed LSB first.
// The register is kept MSB-aligned, so the good-frame residue reads C704DD7B.
module crc32_d8
  import eth_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [7:0]  data,
  output logic [31:0] crc_out
);

  logic [31:0] c;

  // NOTE: blocking assignments here on purpose: each loop iteration must see the
  // value produced by the previous one within the same evaluation.
  always_comb begin
    c = crc_in;
    for (int i = 0; i < 8; i++) begin
      if (c[31] ^ data[i]) c = {c[30:0], 1'b0} ^ CRC32_POLY;
      else                 c = {c[30:0], 1'b0};
    end
    crc_out = c;
  end

endmodule

// File: rtl/udp_rx_parser.sv
// GMII receive parser: Ethernet II / IPv4 / UDP filter with FCS check,
// streams the UDP payload byte-wise with sop/eop markers and a per-frame verdict.
module udp_rx_parser
  import eth_pkg::*;
#(
  parameter logic [47:0] LOCAL_MAC  = 48'h000A3501FEC0,
  parameter logic [31:0] LOCAL_IP   = 32'hC0A80002,
  parameter logic [15:0] LOCAL_PORT = 16'd8080,
  parameter bit          CHECK_FCS  = 1'b1
) (
  input  logic        gmii_rx_clk,
  input  logic        reset,
  input  logic        gmii_rx_dv,
  input  logic [7:0]  gmii_rxd,
  output logic [7:0]  udp_data,
  output logic        udp_data_valid,
  output logic        udp_sop,
  output logic        udp_eop,
  output logic [15:0] udp_len,
  output logic [31:0] udp_src_ip,
  output logic [15:0] udp_src_port,
  output logic        pkt_good,
  output logic        pkt_bad
);

  rx_state_e   state, state_nxt;
  logic [5:0]  hdr_cnt;
  logic [2:0]  pre_cnt;
  logic [39:0] field_sr;
  logic [47:0] field_cur;
  logic [15:0] pay_cnt;
  logic        pay_first;
  logic [31:0] src_ip_q;
  logic [15:0] src_port_q;
  logic [31:0] crc_q, crc_nxt;
  logic        mac_ok, crc_ok;

  crc32_d8 u_crc (
    .crc_in  (crc_q),
    .data    (gmii_rxd),
    .crc_out (crc_nxt)
  );

  // Header fields are compared as they complete, using the bytes seen so far plus the current one.
  assign field_cur = {field_sr, gmii_rxd};
  assign mac_ok    = (field_cur == LOCAL_MAC) || (&field_cur);
  assign crc_ok    = !CHECK_FCS || (crc_q == CRC32_RESIDUE);

  // NOTE: non-blocking assignments for every flop so all registers update from
  // the same pre-edge values regardless of statement order.
  always_ff @(posedge gmii_rx_clk) begin
    if (reset) state <= WAIT_IDLE;
    else       state <= state_nxt;
  end

  // NOTE: state_nxt gets a default before the case so no path leaves it unassigned
  // (which would otherwise infer a latch).
  always_comb begin
    state_nxt = state;
    case (state)
      WAIT_IDLE: if (!gmii_rx_dv) state_nxt = IDLE;
      IDLE:      if (gmii_rx_dv) state_nxt = (gmii_rxd == ETH_PREAMBLE) ? PREAMBLE : DROP;
      PREAMBLE:
        if (!gmii_rx_dv)                 state_nxt = IDLE;
        else if (gmii_rxd == ETH_SFD)    state_nxt = ETH_HDR;
        else if (gmii_rxd != ETH_PREAMBLE || pre_cnt == 3'(PREAMBLE_MAX))
                                         state_nxt = DROP;
      ETH_HDR:
        if (!gmii_rx_dv)                                 state_nxt = IDLE;
        else if (hdr_cnt == ETH_MAC_END && !mac_ok)      state_nxt = DROP;
        else if (hdr_cnt == ETH_TYPE_END)
          state_nxt = (field_cur[15:0] == ETHERTYPE_IPV4) ? IP_HDR : DROP;
      IP_HDR:
        if (!gmii_rx_dv) state_nxt = IDLE;
        else if ((hdr_cnt == IP_VER_IDX   && gmii_rxd != IP_VER_IHL) ||
                 (hdr_cnt == IP_PROTO_IDX && gmii_rxd != IP_PROTO_UDP))
          state_nxt = DROP;
        else if (hdr_cnt == IP_DST_END)
          state_nxt = (field_cur[31:0] == LOCAL_IP) ? UDP_HDR : DROP;
      UDP_HDR:
        if (!gmii_rx_dv) state_nxt = IDLE;
        else if ((hdr_cnt == UDP_DPORT_END && field_cur[15:0] != LOCAL_PORT) ||
                 (hdr_cnt == UDP_LEN_END   && field_cur[15:0] < 16'(UDP_HDR_LEN)))
          state_nxt = DROP;
        else if (hdr_cnt == UDP_HDR_END)
          state_nxt = (pay_cnt == 16'd0) ? TAIL : PAYLOAD;
      PAYLOAD:
        if (!gmii_rx_dv)            state_nxt = IDLE;
        else if (pay_cnt == 16'd1)  state_nxt = TAIL;
      TAIL, DROP: if (!gmii_rx_dv) state_nxt = IDLE;
      default:    state_nxt = WAIT_IDLE;
    endcase
  end

  always_ff @(posedge gmii_rx_clk) begin
    if (reset) begin
      hdr_cnt        <= '0;
      pre_cnt        <= '0;
      field_sr       <= '0;
      pay_cnt        <= '0;
      pay_first      <= 1'b0;
      src_ip_q       <= '0;
      src_port_q     <= '0;
      crc_q          <= CRC32_INIT;
      udp_data       <= '0;
      udp_data_valid <= 1'b0;
      udp_sop        <= 1'b0;
      udp_eop        <= 1'b0;
      udp_len        <= '0;
      udp_src_ip     <= '0;
      udp_src_port   <= '0;
      pkt_good       <= 1'b0;
      pkt_bad        <= 1'b0;
    end else begin
      udp_data_valid <= 1'b0;
      udp_sop        <= 1'b0;
      udp_eop        <= 1'b0;
      pkt_good       <= 1'b0;
      pkt_bad        <= 1'b0;

      if (gmii_rx_dv) field_sr <= field_cur[39:0];

      if (state_nxt != state) hdr_cnt <= '0;
      else if (gmii_rx_dv)    hdr_cnt <= hdr_cnt + 6'd1;

      // pre_cnt counts preamble bytes already seen, including the one that left IDLE.
      if (state == IDLE)                      pre_cnt <= 3'd1;
      else if (state == PREAMBLE && gmii_rx_dv) pre_cnt <= pre_cnt + 3'd1;

      if (state == PREAMBLE)  crc_q <= CRC32_INIT;
      else if (gmii_rx_dv)    crc_q <= crc_nxt;

      if (state == IP_HDR && gmii_rx_dv && hdr_cnt == IP_SRC_END)
        src_ip_q <= field_cur[31:0];

      if (state == UDP_HDR && gmii_rx_dv) begin
        pay_first <= 1'b1;
        if (hdr_cnt == UDP_SPORT_END) src_port_q <= field_cur[15:0];
        if (hdr_cnt == UDP_LEN_END)   pay_cnt <= field_cur[15:0] - 16'(UDP_HDR_LEN);
        // Frame accepted: publish its metadata before the first payload byte.
        if (hdr_cnt == UDP_HDR_END) begin
          udp_len      <= pay_cnt;
          udp_src_ip   <= src_ip_q;
          udp_src_port <= src_port_q;
        end
      end

      if (state == PAYLOAD) begin
        if (gmii_rx_dv) begin
          udp_data       <= gmii_rxd;
          udp_data_valid <= 1'b1;
          udp_sop        <= pay_first;
          udp_eop        <= (pay_cnt == 16'd1);
          pay_first      <= 1'b0;
          pay_cnt        <= pay_cnt - 16'd1;
        end else begin
          pkt_bad <= 1'b1;
        end
      end

      if (state == TAIL && !gmii_rx_dv) begin
        pkt_good <= crc_ok;
        pkt_bad  <= !crc_ok;
      end
    end
  end

endmodule
